// File: rtl/multicycle_cpu.sv
// Multicycle LEGv8-subset core. Each instruction walks FETCH/DECODE/EXEC and,
// as needed, MEM/WB. Separate instruction and data request/ack ports.
module multicycle_cpu #(
   parameter int                DATA_W   = 64,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              halted,
   output logic [31:0]       retired
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
                             OP_LDUR, OP_STUR, OP_CBZ, OP_B, OP_ILL} op_t;

   state_t            state, next_state;
   op_t               op;
   logic [ADDR_W-1:0] pc, addr, pc_plus4, cbz_ofs, b_ofs;
   logic [31:0]       ir;
   logic [DATA_W-1:0] a, b, result, imm12, dofs, rn_val, rm_val;
   logic [DATA_W-1:0] regs [32];
   logic [4:0]        rn, rm, rd;
   logic              retire;

   // Opcode classification; the longer opcode fields are tested first
   always_comb begin
      op = OP_ILL;
      if      (ir[31:21] == 11'b10001011000) op = OP_ADD;
      else if (ir[31:21] == 11'b11001011000) op = OP_SUB;
      else if (ir[31:21] == 11'b10001010000) op = OP_AND;
      else if (ir[31:21] == 11'b10101010000) op = OP_ORR;
      else if (ir[31:21] == 11'b11111000010) op = OP_LDUR;
      else if (ir[31:21] == 11'b11111000000) op = OP_STUR;
      else if (ir[31:22] == 10'b1001000100)  op = OP_ADDI;
      else if (ir[31:22] == 10'b1101000100)  op = OP_SUBI;
      else if (ir[31:24] == 8'b10110100)     op = OP_CBZ;
      else if (ir[31:26] == 6'b000101)       op = OP_B;
   end

   // Instruction fields, immediates and register reads (X31 reads as zero)
   assign rn       = ir[9:5];
   assign rm       = (op == OP_STUR || op == OP_CBZ) ? ir[4:0] : ir[20:16];
   assign rd       = ir[4:0];
   assign imm12    = DATA_W'(ir[21:10]);
   assign dofs     = {{(DATA_W-9){ir[20]}}, ir[20:12]};
   assign cbz_ofs  = {{(ADDR_W-21){ir[23]}}, ir[23:5], 2'b00};
   assign b_ofs    = {{(ADDR_W-28){ir[25]}}, ir[25:0], 2'b00};
   assign pc_plus4 = pc + ADDR_W'(4);
   assign rn_val   = (rn == 5'd31) ? '0 : regs[rn];
   assign rm_val   = (rm == 5'd31) ? '0 : regs[rm];

   assign imem_addr  = pc;
   assign dmem_addr  = addr;
   assign dmem_wdata = b;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before the edge, independent of block order.
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   // Next-state and control outputs
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      next_state = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      retire     = 1'b0;
      halted     = 1'b0;
      case (state)
         FETCH: begin
            // Gated by reset so the request drops the moment reset rises
            imem_req = !reset;
            if (imem_ack) next_state = DECODE;
         end
         DECODE: next_state = (op == OP_ILL) ? HALT : EXEC;
         EXEC: begin
            case (op)
               OP_LDUR, OP_STUR: next_state = MEM;
               OP_CBZ, OP_B: begin
                  retire     = 1'b1;
                  next_state = FETCH;
               end
               default: next_state = WB;
            endcase
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op == OP_STUR);
            if (dmem_ack) begin
               if (op == OP_STUR) begin
                  retire     = 1'b1;
                  next_state = FETCH;
               end else begin
                  next_state = WB;
               end
            end
         end
         WB: begin
            retire     = 1'b1;
            next_state = FETCH;
         end
         HALT:    halted = 1'b1;
         default: next_state = FETCH;
      endcase
   end

   // Datapath registers: IR, operands, result, data address, PC, retire count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= RESET_PC;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         result  <= '0;
         addr    <= '0;
         retired <= '0;
      end else begin
         if (retire) retired <= retired + 32'd1;
         case (state)
            FETCH:  if (imem_ack) ir <= imem_rdata;
            DECODE: begin
               a <= rn_val;
               b <= rm_val;
            end
            EXEC: begin
               case (op)
                  OP_ADD:           result <= a + b;
                  OP_SUB:           result <= a - b;
                  OP_AND:           result <= a & b;
                  OP_ORR:           result <= a | b;
                  OP_ADDI:          result <= a + imm12;
                  OP_SUBI:          result <= a - imm12;
                  OP_LDUR, OP_STUR: addr   <= ADDR_W'(a + dofs);
                  OP_CBZ:           pc     <= (b == '0) ? pc + cbz_ofs : pc_plus4;
                  OP_B:             pc     <= pc + b_ofs;
                  default:          ;
               endcase
            end
            MEM: begin
               if (dmem_ack) begin
                  if (op == OP_STUR) pc     <= pc_plus4;
                  else               result <= dmem_rdata;
               end
            end
            WB:      pc <= pc_plus4;
            default: ;
         endcase
      end
   end

   // Register file: cleared on reset, written in WB; writes to X31 are dropped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the register file is built from resettable flops rather than
         // a RAM because every architectural register must be zero after reset.
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (state == WB && rd != 5'd31) begin
         regs[rd] <= result;
      end
   end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning datapath and register width (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width of both memory ports.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the fetch address after reset.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  meaning the reset, asynchronous and active-high.
REQ-006 SHALL have port imem_req  out  1  meaning the instruction-fetch request.
REQ-007 SHALL have port imem_addr  out  ADDR_W  meaning the fetch byte address (equals PC).
REQ-008 SHALL have port imem_ack  in  1  meaning fetch complete; imem_rdata is valid in this cycle.
REQ-009 SHALL have port imem_rdata  in  32  meaning the instruction word.
REQ-010 SHALL have port dmem_req  out  1  meaning the data-memory request.
REQ-011 SHALL have port dmem_we  out  1  meaning 1 = store, 0 = load; valid while dmem_req is high.
REQ-012 SHALL have port dmem_addr  out  ADDR_W  meaning the data byte address.
REQ-013 SHALL have port dmem_wdata  out  DATA_W  meaning the store data.
REQ-014 SHALL have port dmem_ack  in  1  meaning data access complete; dmem_rdata is valid on loads.
REQ-015 SHALL have port dmem_rdata  in  DATA_W  meaning the load data.
REQ-016 SHALL have port halted  out  1  meaning the core has stopped on an illegal opcode.
REQ-017 SHALL have port retired  out  32  meaning the count of retired instructions.

Function
REQ-018 SHALL implement an FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-019 SHALL, in FETCH, hold imem_req=1 and imem_addr=PC until imem_ack=1, then latch imem_rdata into IR and go to DECODE.
REQ-020 SHALL, in DECODE, read Rn=IR[9:5] and Rm (IR[20:16] for R-type, IR[4:0] for STUR/CBZ) into operand registers A and B.
REQ-021 SHALL decode ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010 and STUR 11111000000 on IR[31:21].
REQ-022 SHALL decode ADDI 1001000100 and SUBI 1101000100 on IR[31:22], CBZ 10110100 on IR[31:24], and B 000101 on IR[31:26].
REQ-023 SHALL enter HALT from DECODE on any other opcode, set halted=1, and stay in HALT until reset.
REQ-024 SHALL, in EXEC, compute ALU ops modulo 2^DATA_W; ADDI/SUBI zero-extend the 12-bit immediate IR[21:10]; LDUR/STUR address = A + sign-extended IR[20:12].
REQ-025 SHALL, in EXEC for CBZ, set PC = PC + (sign-extended IR[23:5] << 2) if B==0, else PC+4; for B, PC = PC + (sign-extended IR[25:0] << 2); then retire and go to FETCH.
REQ-026 SHALL compute all PC arithmetic modulo 2^ADDR_W (wrap-around, no trap).
REQ-027 SHALL, in MEM, hold dmem_req=1 with stable dmem_addr, dmem_we and dmem_wdata (=B) until dmem_ack=1.
REQ-028 SHALL, on STUR ack, set PC += 4, retire and go to FETCH; on LDUR ack, latch dmem_rdata and go to WB.
REQ-029 SHALL, in WB, write the result to Rd=IR[4:0], set PC += 4, retire and go to FETCH.
REQ-030 SHALL treat X31 as XZR: reads return 0 and writes are discarded.
REQ-031 SHALL ignore imem_ack and dmem_ack while the corresponding req is 0.
REQ-032 SHALL never assert imem_req and dmem_req in the same cycle.
REQ-033 SHALL increment retired by 1 on each retirement, wrapping at 2^32.
REQ-034 SHALL take the following cycle counts with zero-wait acks (ack in the first req cycle): R/I-type 4, CBZ/B 3, STUR 4, LDUR 5.

Reset
REQ-035 SHALL, while reset=1, force state=FETCH, PC=RESET_PC, imem_req=0, dmem_req=0, dmem_we=0, halted=0, retired=0, and all registers to 0.
REQ-036 SHALL abandon any in-flight memory transaction on reset, with requests dropping asynchronously.
REQ-037 SHALL assert imem_req in the first clk edge cycle after reset deasserts.

Verification
REQ-038 SHALL be verified by this scenario: ADDI X1,XZR,#5; ADDI X2,XZR,#7; ADD X3,X1,X2, zero-wait -> X3=12, retired=3, 12 cycles.
REQ-039 SHALL be verified by this scenario: STUR X3,[XZR,#8] then LDUR X4,[XZR,#8], with a 3-cycle dmem_ack delay -> dmem_addr=8, dmem_wdata=12, req held 3 cycles, X4=12.
REQ-040 SHALL be verified by this scenario: CBZ XZR,#-2 at PC=0x10 -> next imem_addr=0x08; CBZ X1(=5) -> next imem_addr=0x14.
REQ-041 SHALL be verified by this scenario: SUBI X5,XZR,#1 with DATA_W=32 -> X5=0xFFFFFFFF; ADD X31,X1,X1 -> X31 reads 0.
REQ-042 SHALL be verified by this scenario: word 0x00000000 fetched -> halted=1, no further imem_req, retired unchanged.
REQ-043 SHALL be verified by this scenario: reset asserted mid-MEM with dmem_req=1 -> dmem_req=0 immediately; after release imem_addr=RESET_PC.
